// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - state encodings and write_type constants shared by the dmem responder files
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DRAIN,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] WT_BYTE = 4'b0001;
    localparam logic [3:0] WT_HALF = 4'b0011;
    localparam logic [3:0] WT_WORD = 4'b1111;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering for stores and load data right-justification
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [3:0]  write_type,
    input  logic [1:0]  wr_off,
    input  logic [31:0] w_data,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    always_comb begin
        wstrb = write_type << wr_off;
        // replicate the store across all lanes so the strobe alone selects the bytes
        case (write_type)
            WT_BYTE: wdata = {4{w_data[7:0]}};
            WT_HALF: wdata = {2{w_data[15:0]}};
            default: wdata = w_data;
        endcase
        rdata = rd_word >> {rd_off, 3'b000};
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder driving a req/gnt memory bus
// Optional DMEM_POSTED_WR_EN: single-entry posted store buffer with early wready.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rvalid,
    input  logic              wvalid,
    input  logic              op,
    input  logic [3:0]        write_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              uncache,
    input  logic              flush,
    output logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              wready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_uncache,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_bvalid
);

    state_t            state;
    logic [1:0]        rd_off;
    logic [ADDR_W-1:0] addr_al;
    logic [3:0]        wstrb_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rdata_c;
    logic              bg_busy;

    assign addr_al = {addr[ADDR_W-1:2], 2'b00};

    dmem_lane_align u_align (
        .write_type (write_type),
        .wr_off     (addr[1:0]),
        .w_data     (w_data),
        .rd_off     (rd_off),
        .rd_word    (mem_rdata),
        .wstrb      (wstrb_c),
        .wdata      (wdata_c),
        .rdata      (rdata_c)
    );

`ifdef DMEM_POSTED_WR_EN
    logic              pb_pending;
    logic              ld_hold;
    logic              ld_uncache;
    logic [ADDR_W-1:0] ld_addr;

    // busy value to use when the FSM settles in IDLE this cycle
    assign bg_busy = pb_pending & ~mem_bvalid;
`else
    assign bg_busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rready      <= 1'b0;
            wready      <= 1'b0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_uncache <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            rd_off      <= 2'b00;
`ifdef DMEM_POSTED_WR_EN
            pb_pending  <= 1'b0;
            ld_hold     <= 1'b0;
            ld_uncache  <= 1'b0;
            ld_addr     <= '0;
`endif
        end else begin
            rready <= 1'b0;
            wready <= 1'b0;
`ifdef DMEM_POSTED_WR_EN
            // background drain of the buffered store; the FSM below may override mem_req
            if (pb_pending && mem_we && mem_gnt) mem_req <= 1'b0;
            if (pb_pending && mem_bvalid) pb_pending <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    busy <= bg_busy;
                    if (rvalid || wvalid) begin
                        if (op) begin
`ifdef DMEM_POSTED_WR_EN
                            if (!pb_pending) begin
                                mem_req     <= 1'b1;
                                mem_we      <= 1'b1;
                                mem_addr    <= addr_al;
                                mem_uncache <= uncache;
                                mem_wstrb   <= wstrb_c;
                                mem_wdata   <= wdata_c;
                                pb_pending  <= 1'b1;
                                wready      <= 1'b1;
                                busy        <= 1'b1;
                            end
`else
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b1;
                            mem_addr    <= addr_al;
                            mem_uncache <= uncache;
                            mem_wstrb   <= wstrb_c;
                            mem_wdata   <= wdata_c;
                            busy        <= 1'b1;
                            state       <= ST_WR_REQ;
`endif
                        end else begin
                            rd_off <= addr[1:0];
                            busy   <= 1'b1;
                            state  <= ST_RD_REQ;
`ifdef DMEM_POSTED_WR_EN
                            if (pb_pending) begin
                                ld_hold    <= 1'b1;
                                ld_addr    <= addr_al;
                                ld_uncache <= uncache;
                            end else begin
                                mem_req     <= 1'b1;
                                mem_we      <= 1'b0;
                                mem_addr    <= addr_al;
                                mem_uncache <= uncache;
                            end
`else
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_addr    <= addr_al;
                            mem_uncache <= uncache;
`endif
                        end
                    end
                end
                ST_RD_REQ: begin
`ifdef DMEM_POSTED_WR_EN
                    if (ld_hold) begin
                        if (flush) begin
                            ld_hold <= 1'b0;
                            busy    <= bg_busy;
                            state   <= ST_IDLE;
                        end else if (!pb_pending || mem_bvalid) begin
                            ld_hold     <= 1'b0;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_addr    <= ld_addr;
                            mem_uncache <= ld_uncache;
                        end
                    end else
`endif
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid && flush) begin
                            busy  <= bg_busy;
                            state <= ST_IDLE;
                        end else if (mem_rvalid) begin
                            rdata  <= rdata_c;
                            rready <= 1'b1;
                            state  <= ST_RESP;
                        end else begin
                            state <= flush ? ST_RD_DRAIN : ST_RD_WAIT;
                        end
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        busy    <= bg_busy;
                        state   <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid && flush) begin
                        busy  <= bg_busy;
                        state <= ST_IDLE;
                    end else if (mem_rvalid) begin
                        rdata  <= rdata_c;
                        rready <= 1'b1;
                        state  <= ST_RESP;
                    end else if (flush) begin
                        state <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (mem_rvalid) begin
                        busy  <= bg_busy;
                        state <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_bvalid) begin
                        wready <= 1'b1;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy  <= bg_busy;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
